// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared definitions for the Keccak round sequencer:
//   ROUND_IDX_W        width of the round index (5 bits covers 0..23)
//   KECCAK_ROUNDS_MAX  rounds of the full Keccak-f[1600] permutation
//   kstate_e           sequencer FSM states
//   first_round()      first round index used for a given round count
// -----------------------------------------------------------------------------
package keccak_pkg;

   localparam int ROUND_IDX_W       = 5;
   localparam int KECCAK_ROUNDS_MAX = 24;

   localparam logic [ROUND_IDX_W-1:0] LAST_ROUND_IDX = ROUND_IDX_W'(KECCAK_ROUNDS_MAX - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } kstate_e;

   // Reduced-round variants use the tail of the index range, so the last
   // round is always index 23 regardless of the round count.
   function automatic logic [ROUND_IDX_W-1:0] first_round(input int nr);
      return ROUND_IDX_W'(KECCAK_ROUNDS_MAX - nr);
   endfunction

endpackage

// File: rtl/keccak_round_counter.sv
// -----------------------------------------------------------------------------
// keccak_round_counter
// Round index register. Loads FIRST_ROUND, counts up on increment and flags
// the final round index.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-high reset (counter returns to FIRST_ROUND)
//   i_load  reload FIRST_ROUND (wins over i_inc)
//   i_inc   advance the index by one
//   o_cnt   current round index
//   o_last  index is the final round (23)
// -----------------------------------------------------------------------------
module keccak_round_counter
   import keccak_pkg::*;
#(
   parameter logic [ROUND_IDX_W-1:0] FIRST_ROUND = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_load,
   input  logic                   i_inc,
   output logic [ROUND_IDX_W-1:0] o_cnt,
   output logic                   o_last
);

   logic [ROUND_IDX_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       r_cnt <= FIRST_ROUND;
      else if (i_load) r_cnt <= FIRST_ROUND;
      else if (i_inc)  r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == LAST_ROUND_IDX);

endmodule

// File: rtl/keccak_round_ctrl.sv
// -----------------------------------------------------------------------------
// keccak_round_ctrl
// Round sequencer for the iterative Keccak-p[1600,NUM_ROUNDS] core. Accepts a
// start request, steps the round index FIRST_ROUND..23 one per cycle, then
// holds a completion flag until the consumer accepts it.
// Parameters:
//   NUM_ROUNDS      rounds per permutation, 1..24
// Configuration:
//   KECCAK_ROUND_ABORT_EN  adds abort_i, which cancels a run in RUN or DONE
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   start_valid_i   start request    / start_ready_o  high in IDLE
//   round_en_o      datapath applies a round this cycle
//   round_number_o  round index for the round-constant lookup
//   first_round_o   first RUN cycle  / last_round_o   final RUN cycle
//   done_valid_o    result stable    / done_ready_i   consumer accepts it
//   abort_i         (optional) cancel the current permutation
//   busy_o          high in RUN or DONE
// All outputs decode registered state only; no input-to-output paths.
// -----------------------------------------------------------------------------
module keccak_round_ctrl
   import keccak_pkg::*;
#(
   parameter int NUM_ROUNDS = 24
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_valid_i,
   output logic                   start_ready_o,
   output logic                   round_en_o,
   output logic [ROUND_IDX_W-1:0] round_number_o,
   output logic                   first_round_o,
   output logic                   last_round_o,
   output logic                   done_valid_o,
   input  logic                   done_ready_i,
`ifdef KECCAK_ROUND_ABORT_EN
   input  logic                   abort_i,
`endif
   output logic                   busy_o
);

   if (NUM_ROUNDS < 1 || NUM_ROUNDS > KECCAK_ROUNDS_MAX) begin : g_bad_rounds
      $error("keccak_round_ctrl: NUM_ROUNDS must be within 1..24");
   end

   localparam logic [ROUND_IDX_W-1:0] FIRST_ROUND = first_round(NUM_ROUNDS);

   kstate_e                r_state;
   logic [ROUND_IDX_W-1:0] w_cnt;
   logic                   w_last;
   logic                   w_start;
   logic                   w_abort;
   logic                   w_load;
   logic                   w_inc;

`ifdef KECCAK_ROUND_ABORT_EN
   assign w_abort = abort_i & (r_state != IDLE);
`else
   assign w_abort = 1'b0;
`endif

   assign w_start = (r_state == IDLE) & start_valid_i;

   // Reload on acceptance, on the final round (so cnt sits at FIRST_ROUND
   // throughout DONE/IDLE) and on abort; otherwise count while running.
   assign w_load = w_start | w_abort | ((r_state == RUN) & w_last);
   assign w_inc  = (r_state == RUN) & ~w_last;

   keccak_round_counter #(
      .FIRST_ROUND (FIRST_ROUND)
   ) u_cnt (
      .i_clk  (clk_i),
      .i_rst  (rst_i),
      .i_load (w_load),
      .i_inc  (w_inc),
      .o_cnt  (w_cnt),
      .o_last (w_last)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: if (start_valid_i) r_state <= RUN;
            RUN: begin
               if (w_abort)     r_state <= IDLE;
               else if (w_last) r_state <= DONE;
            end
            DONE: begin
               // A start seen here is dropped; acceptance needs IDLE first.
               if (w_abort || done_ready_i) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign start_ready_o  = (r_state == IDLE);
   assign round_en_o     = (r_state == RUN);
   assign round_number_o = w_cnt;
   assign first_round_o  = (r_state == RUN) & (w_cnt == FIRST_ROUND);
   assign last_round_o   = (r_state == RUN) & w_last;
   assign done_valid_o   = (r_state == DONE);
   assign busy_o         = (r_state == RUN) | (r_state == DONE);

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keccak_round_ctrl
// Drives three sequencers (24, 12 and 1 rounds) from shared stimulus and
// compares every output on every falling edge against a round-count model.
// -----------------------------------------------------------------------------
module tb_keccak_round_ctrl;

   localparam int N = 3;
   localparam int NRS [N] = '{24, 12, 1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_v = 1'b0;
   logic done_r = 1'b0;
   logic ab = 1'b0;

   logic [N-1:0] rdy, en, fr, lr, dv, bz;
   logic [4:0]   rn [N];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      keccak_round_ctrl #(.NUM_ROUNDS(NRS[g])) dut (
         .clk_i          (clk),
         .rst_i          (rst),
         .start_valid_i  (start_v),
         .start_ready_o  (rdy[g]),
         .round_en_o     (en[g]),
         .round_number_o (rn[g]),
         .first_round_o  (fr[g]),
         .last_round_o   (lr[g]),
         .done_valid_o   (dv[g]),
         .done_ready_i   (done_r),
`ifdef KECCAK_ROUND_ABORT_EN
         .abort_i        (ab),
`endif
         .busy_o         (bz[g])
      );
   end

   // Model: rounds still to apply, and whether a result awaits the consumer.
   int left  [N] = '{0, 0, 0};
   bit dpend [N] = '{0, 0, 0};

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            left[i] = 0; dpend[i] = 0;
         end else if (ab && (left[i] > 0 || dpend[i])) begin
            left[i] = 0; dpend[i] = 0;
         end else if (left[i] > 0) begin
            left[i] = left[i] - 1;
            if (left[i] == 0) dpend[i] = 1;
         end else if (dpend[i]) begin
            if (done_r) dpend[i] = 0;
         end else if (start_v) begin
            left[i] = NRS[i];
         end
      end
   end

   // Continuous comparison on the falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         bit        run;
         logic [4:0] e_rn;
         logic [5:0] e_f, a_f;
         run  = left[i] > 0;
         e_rn = run ? 5'(24 - left[i]) : 5'(24 - NRS[i]);
         e_f  = {!run && !dpend[i], run, run && left[i] == NRS[i],
                 run && left[i] == 1, dpend[i], run || dpend[i]};
         a_f  = {rdy[i], en[i], fr[i], lr[i], dv[i], bz[i]};
         vectors++;
         if (a_f !== e_f || rn[i] !== e_rn) begin
            miscompares++;
            $display("FAIL cycle dut%0d t=%0t flags(rdy,en,fr,lr,dv,bz) got %b want %b rn got %0d want %0d",
                     i, $time, a_f, e_f, rn[i], e_rn);
         end
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic lit(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   int first_rn [N] = '{0, 12, 23};
   int lat_done [N] = '{25, 13, 2};
   int k_done [N];
   int k_last [N];
   int k_rdy0;

   initial begin
      repeat (2) tick();
      rst = 1'b0;
      // Reset / idle
      for (int c = 0; c < 10; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            lit("idle_rn", rn[i], first_rn[i]);
         end
         lit("idle_rdy", rdy, 3'b111);
      end

      // Directed latency run, done_ready held high
      done_r  = 1'b1;
      start_v = 1'b1;
      tick();                       // start accepted at the edge before this
      start_v = 1'b0;
      for (int i = 0; i < N; i++) begin k_done[i] = -1; k_last[i] = -1; end
      k_rdy0 = -1;
      for (int k = 1; k <= 30; k++) begin
         for (int i = 0; i < N; i++) begin
            if (k == 1) begin
               lit("first_rn", rn[i], first_rn[i]);
               lit("first_flag", int'(fr[i]), 1);
            end
            if (dv[i] && k_done[i] < 0) k_done[i] = k;
            if (lr[i] && k_last[i] < 0) begin
               k_last[i] = k;
               lit("last_rn", rn[i], 23);
            end
         end
         if (k_done[0] > 0 && rdy[0] && k_rdy0 < 0) k_rdy0 = k;
         if (k < 30) tick();
      end
      for (int i = 0; i < N; i++) begin
         lit("done_latency", k_done[i], lat_done[i]);
         lit("last_cycle", k_last[i], NRS[i]);
      end
      lit("ready_again", k_rdy0, 26);

      // Backpressure: result held, extra starts ignored
      done_r  = 1'b0;
      start_v = 1'b1;
      tick();
      for (int c = 0; c < 40; c++) begin
         start_v = 1'($urandom_range(0, 1));
         tick();
      end
      lit("held_done", dv, 3'b111);
      start_v = 1'b0;
      done_r  = 1'b1;
      tick();
      tick();
      lit("released", rdy, 3'b111);

      // Reset mid-run at round 7 of the 24-round instance
      start_v = 1'b1;
      tick();
      start_v = 1'b0;
      repeat (7) tick();
      lit("pre_rst_rn", rn[0], 7);
      rst = 1'b1;
      #1;
      lit("async_rst_rn0", rn[0], 0);
      lit("async_rst_rn1", rn[1], 12);
      lit("async_rst_flags", {rdy[0], en[0], dv[0], bz[0]}, 4'b1000);
      tick();
      rst = 1'b0;
      repeat (30) tick();

`ifdef KECCAK_ROUND_ABORT_EN
      start_v = 1'b1;
      tick();
      start_v = 1'b0;
      repeat (7) tick();
      ab = 1'b1;
      tick();
      ab = 1'b0;
      lit("abort_rn0", rn[0], 0);
      lit("abort_flags", {rdy[0], en[0], dv[0], bz[0]}, 4'b1000);
      repeat (30) tick();
`endif

      // Random traffic
      for (int c = 0; c < 2000; c++) begin
         start_v = ($urandom_range(0, 99) < 50);
         done_r  = ($urandom_range(0, 99) < 30);
`ifdef KECCAK_ROUND_ABORT_EN
         ab      = ($urandom_range(0, 99) < 3);
`endif
         if ($urandom_range(0, 999) == 0) begin
            rst = 1'b1;
            #1;
            lit("rand_rst_rdy", rdy, 3'b111);
            tick();
            rst = 1'b0;
         end else begin
            tick();
         end
      end
      ab = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keccak_round_ctrl.md
# keccak_round_ctrl

Round sequencer for the iterative Keccak-f[1600]/Keccak-p[1600,nr] permutation core. It accepts a permutation request through a valid/ready handshake and steps a 5-bit round index through the configured rounds, one per cycle. The index drives the round-constant lookup and the iota step. It also emits per-cycle strobes for the state datapath and holds a completion flag until the consumer accepts it.

## Interface
Parameters:
- NUM_ROUNDS, 24, rounds per permutation, legal range 1..24. The round indices used are the last NUM_ROUNDS of 0..23, so FIRST_ROUND = 24 − NUM_ROUNDS (e.g. 12 gives indices 12..23).

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_valid_i  in  1  request to run one permutation on the currently loaded state.
- start_ready_o  out  1  high only in IDLE.
- round_en_o  out  1  datapath applies one round this cycle.
- round_number_o  out  5  index of the round applied this cycle; feeds the round-constant lookup.
- first_round_o  out  1  high in the first RUN cycle.
- last_round_o  out  1  high in the final RUN cycle.
- done_valid_o  out  1  permutation result is stable in the state register.
- done_ready_i  in  1  consumer accepts the result.
- busy_o  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. There is also a 5-bit counter cnt.
- Transitions:
  - IDLE → RUN on start_valid_i & start_ready_o; cnt ← FIRST_ROUND.
  - RUN: cnt ← cnt+1 each cycle. When cnt == 23, RUN → DONE and cnt ← FIRST_ROUND.
  - DONE → IDLE on done_ready_i.
- Outputs:
  - round_number_o = cnt in every state. It equals FIRST_ROUND outside RUN and never exceeds 23; no wrap-around is possible.
  - round_en_o = (state==RUN).
  - first_round_o = RUN & (cnt==FIRST_ROUND).
  - last_round_o = RUN & (cnt==23).
  - done_valid_o = (state==DONE).
- Boundary cases:
  - With NUM_ROUNDS = 1, first_round_o and last_round_o are asserted in the same cycle.
  - start_valid_i outside IDLE is ignored and not queued. The requester must hold valid until ready.
  - In DONE, a start_valid_i coinciding with done_ready_i is ignored. A new start is accepted no earlier than the cycle after returning to IDLE.
  - done_valid_o stays high while done_ready_i is low, for any number of cycles.
  - Reset asserted mid-RUN or mid-DONE returns the block to IDLE immediately and discards the permutation in progress.
- Reset values: state IDLE, cnt FIRST_ROUND.
  - Hence start_ready_o = 1, round_number_o = FIRST_ROUND.
  - round_en_o, first_round_o, last_round_o, done_valid_o, busy_o all = 0.

## Timing
- Start accepted at edge T: RUN cycles are T+1 … T+NUM_ROUNDS, with round_number_o = FIRST_ROUND … 23.
- done_valid_o rises at cycle T+NUM_ROUNDS+1.
- Latency from start acceptance to done_valid_o is NUM_ROUNDS+1 cycles.
- If done_ready_i is high in the first DONE cycle, start_ready_o is high again the next cycle. Minimum issue interval: NUM_ROUNDS+2 cycles.
- All outputs are decoded combinationally from registered state/cnt only; there are no input-to-output combinational paths.

## Configuration
- KECCAK_ROUND_ABORT_EN defined:
  - Adds input abort_i (1 bit).
  - abort_i high in RUN or DONE forces IDLE and cnt ← FIRST_ROUND at the next edge. No done_valid_o is produced for an aborted run.
  - abort_i has priority over done_ready_i and over the RUN→DONE transition.
  - abort_i is ignored in IDLE.
- Macro undefined: abort_i does not exist. A permutation always runs to completion.

## Structure
- keccak_pkg holds:
  - ROUND_IDX_W = 5 and KECCAK_ROUNDS_MAX = 24.
  - The FSM state enum typedef (IDLE, RUN, DONE).
  - A function computing FIRST_ROUND from NUM_ROUNDS.
- A parameter check (elaboration-time error) rejects NUM_ROUNDS outside 1..24.
- One natural sub-module, keccak_round_counter. It loads FIRST_ROUND, increments on enable, and flags cnt==23.
- The FSM stays in keccak_round_ctrl. The round-constant lookup stays external.

## Test plan
- Reset then idle: after rst_i deassert, start_ready_o=1, round_number_o=0, done_valid_o=0, for 10 idle cycles.
- NUM_ROUNDS=24, start at T, done_ready_i held 1:
  - round_en_o high T+1..T+24, with round_number_o 0..23.
  - first_round_o at T+1, last_round_o at T+24.
  - done_valid_o one cycle at T+25; start_ready_o=1 at T+26.
- NUM_ROUNDS=12: round_number_o sequence 12..23; done_valid_o at T+13.
- Backpressure: done_ready_i low for 5 cycles. done_valid_o holds 5+ cycles, and start_valid_i pulses during RUN and DONE are ignored (exactly one permutation observed).
- NUM_ROUNDS=1: first_round_o=last_round_o=1 at T+1 with round_number_o=23; done_valid_o at T+2.
- Reset mid-run at round 7: all outputs return to reset values asynchronously, and no done_valid_o is produced. With KECCAK_ROUND_ABORT_EN, abort_i at round 7 gives the same result at the next edge.
